// File: rtl/expr_string_gen.sv
// rtl/expr_string_gen.sv - serializes a packed digit/operator expression as an ASCII byte stream
// Emits digit(op digit)* one byte per transfer; a start with illegal operands pulses err instead.
module expr_string_gen #(
  parameter int MAX_OPS = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             num_operands,
  input  logic [4*MAX_OPS-1:0]   operands,
  input  logic [MAX_OPS-2:0]     ops,
  output logic [7:0]             out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err
);

  localparam int KW = $clog2(MAX_OPS);

  typedef enum logic [1:0] {S_IDLE, S_DIGIT, S_OP} state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [3:0]        r_last_idx;
  logic [3:0]        r_opnd [MAX_OPS];
  logic [MAX_OPS-2:0] r_ops;
  logic [7:0]        r_out;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_err;

  logic              w_ok;
  logic              w_xfer;
  logic              w_at_last;
  logic [KW-1:0]     w_k_inc;
  logic              w_next_last;

  // Only operands below the requested count are range-checked; the rest are don't-care.
  always_comb begin
    w_ok = (num_operands != 4'd0) && (num_operands <= 4'(MAX_OPS));
    for (int i = 0; i < MAX_OPS; i++) begin
      if ((4'(i) < num_operands) && (operands[4*i +: 4] > 4'd9)) begin
        w_ok = 1'b0;
      end
    end
  end

  assign w_xfer      = r_valid & out_ready;
  assign w_at_last   = (4'(r_k) == r_last_idx);
  assign w_k_inc     = r_k + KW'(1);
  assign w_next_last = (4'(w_k_inc) == r_last_idx);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_last_idx <= 4'd0;
      r_out      <= 8'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_ok) begin
              for (int i = 0; i < MAX_OPS; i++) begin
                r_opnd[i] <= operands[4*i +: 4];
              end
              r_ops      <= ops;
              r_k        <= '0;
              r_last_idx <= num_operands - 4'd1;
              r_out      <= 8'd48 + {4'd0, operands[3:0]};
              r_valid    <= 1'b1;
              r_last     <= (num_operands == 4'd1);
              r_busy     <= 1'b1;
              r_state    <= S_DIGIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_DIGIT: begin
          if (w_xfer) begin
            if (w_at_last) begin
              r_out   <= 8'd0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_out   <= r_ops[r_k] ? 8'd43 : 8'd42;
              r_last  <= 1'b0;
              r_state <= S_OP;
            end
          end
        end
        S_OP: begin
          if (w_xfer) begin
            r_k     <= w_k_inc;
            r_out   <= 8'd48 + {4'd0, r_opnd[w_k_inc]};
            r_last  <= w_next_last;
            r_state <= S_DIGIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_expr_string_gen.sv
// tb/tb_expr_string_gen.sv - directed table-driven bench for expr_string_gen
module tb_expr_string_gen;

  localparam int MAX_OPS = 8;

  logic                 clk = 1'b0;
  logic                 clr;
  logic                 start;
  logic [3:0]           num_operands;
  logic [4*MAX_OPS-1:0] operands;
  logic [MAX_OPS-2:0]   ops;
  logic [7:0]           out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 err;

  int n_pass = 0;
  int n_total = 0;

  expr_string_gen #(.MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .clr(clr), .start(start), .num_operands(num_operands),
    .operands(operands), .ops(ops), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  n;
    logic [31:0] opnds;
    logic [6:0]  opsv;
    logic        exp_err;
    string       exp_str;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] n, input logic [31:0] o, input logic [6:0] p);
    num_operands = n;
    operands     = o;
    ops          = p;
  endtask

  // Pulses start for one cycle, then drains the stream with out_ready high.
  task automatic run_vec(input vec_t v);
    load(v.n, v.opnds, v.opsv);
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    if (v.exp_err) begin
      chk({v.name, " err pulse"}, err, 1);
      chk({v.name, " no valid"}, out_valid, 0);
      step();
      chk({v.name, " err cleared"}, err, 0);
      chk({v.name, " still idle"}, out_valid | busy, 0);
    end else begin
      chk({v.name, " no err"}, err, 0);
      for (int j = 0; j < v.exp_str.len(); j++) begin
        chk($sformatf("%s byte%0d", v.name, j), out, v.exp_str.getc(j));
        chk($sformatf("%s valid%0d", v.name, j), out_valid, 1);
        chk($sformatf("%s last%0d", v.name, j), out_last, (j == v.exp_str.len() - 1));
        chk($sformatf("%s busy%0d", v.name, j), busy, 1);
        step();
      end
      chk({v.name, " done valid"}, out_valid, 0);
      chk({v.name, " done busy"}, busy, 0);
      chk({v.name, " done out"}, out, 0);
    end
  endtask

  task automatic expect_byte(input string name, input byte b, input logic lst);
    chk({name, " byte"}, out, b);
    chk({name, " valid"}, out_valid, 1);
    chk({name, " last"}, out_last, lst);
  endtask

  initial begin
    vecs[0] = '{"v_3ops",  4'd3, 32'h0000_0110, 7'b0000010, 1'b0, "0*1+1"};
    vecs[1] = '{"v_single",4'd1, 32'h0000_0007, 7'b0000000, 1'b0, "7"};
    vecs[2] = '{"v_max",   4'd8, 32'h2345_6789, 7'b1010101, 1'b0, "9+8*7+6*5+4*3+2"};
    vecs[3] = '{"v_5p9",   4'd2, 32'h0000_0095, 7'b0000001, 1'b0, "5+9"};
    vecs[4] = '{"e_n0",    4'd0, 32'h0000_0000, 7'b0000000, 1'b1, ""};
    vecs[5] = '{"e_n9",    4'd9, 32'h0000_0000, 7'b0000000, 1'b1, ""};
    vecs[6] = '{"e_op10",  4'd3, 32'h0000_00A0, 7'b0000000, 1'b1, ""};
    vecs[7] = '{"v_unused",4'd2, 32'hFFFF_FF34, 7'b1111110, 1'b0, "4*3"};

    clr = 1'b1; start = 1'b0; out_ready = 1'b1;
    load(4'd0, 32'd0, 7'd0);
    step(); step();
    chk("reset out", out, 0);
    chk("reset valid", out_valid, 0);
    chk("reset last", out_last, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    clr = 1'b0;
    step();

    // Consecutive vectors also exercise back-to-back starts on the first idle cycle.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: hold '*' for three stalled cycles.
    load(4'd3, 32'h110, 7'b0000010);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_byte("bp 0", 8'd48, 1'b0);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_byte($sformatf("bp hold%0d", c), 8'd42, 1'b0);
      step();
    end
    out_ready = 1'b1;
    expect_byte("bp 1", 8'd42, 1'b0); step();
    expect_byte("bp 2", 8'd49, 1'b0); step();
    expect_byte("bp 3", 8'd43, 1'b0); step();
    expect_byte("bp 4", 8'd49, 1'b1); step();
    chk("bp done", out_valid | busy, 0);

    // Clear mid-string abandons it.
    start = 1'b1;
    step();
    start = 1'b0;
    expect_byte("clr 0", 8'd48, 1'b0); step();
    expect_byte("clr 1", 8'd42, 1'b0); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr valid", out_valid, 0);
    chk("clr busy", busy, 0);
    chk("clr out", out, 0);
    run_vec(vecs[3]);

    // Start held with different data while busy must be ignored.
    load(4'd3, 32'h110, 7'b0000010);
    start = 1'b1;
    step();
    load(4'd2, 32'h95, 7'b0000001);
    expect_byte("ign 0", 8'd48, 1'b0); chk("ign err0", err, 0); step();
    expect_byte("ign 1", 8'd42, 1'b0); chk("ign err1", err, 0); step();
    expect_byte("ign 2", 8'd49, 1'b0); chk("ign err2", err, 0); step();
    expect_byte("ign 3", 8'd43, 1'b0); chk("ign err3", err, 0); step();
    expect_byte("ign 4", 8'd49, 1'b1); chk("ign err4", err, 0);
    start = 1'b0;
    step();
    chk("ign done", out_valid | busy | err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
